// File: rtl/neuron_integrate_fire.sv
// Leaky integrate-and-fire membrane stage.
// Accumulates the clamped adder-tree sum (or full scale on adder overflow)
// into a saturating, leaky membrane potential; fires a one-cycle spike on
// threshold crossing and then blocks input for REFRAC cycles.
// Build option: define NEURON_SOFT_RESET_EN to subtract THRESH on fire
// (residue retained) instead of clearing the membrane to zero.
module neuron_integrate_fire #(
  parameter int N      = 8,
  parameter int ACC_W  = 12,
  parameter int THRESH = 512,
  parameter int LEAK   = 1,
  parameter int REFRAC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_sat,
  output logic             spike,
  output logic [ACC_W-1:0] vmem,
  output logic [15:0]      spike_cnt,
  output logic [1:0]       state
);

  localparam int CNT_W = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
  localparam logic [ACC_W:0]   LEAK_X   = (ACC_W + 1)'(LEAK);
  localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);
  localparam logic [CNT_W-1:0] REFRAC_V = CNT_W'(REFRAC);

  typedef enum logic [1:0] {
    ST_INTEG  = 2'd0,
    ST_FIRE   = 2'd1,
    ST_REFRAC = 2'd2
  } state_t;

  state_t           cur_state;
  state_t           next_state;
  logic [CNT_W-1:0] refrac_cnt;
  logic [CNT_W-1:0] refrac_cnt_next;
  logic [ACC_W-1:0] vmem_next;
  logic [15:0]      spike_cnt_next;
  logic [N-1:0]     x;
  logic             transfer;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] leaked;

  assign in_ready = (cur_state == ST_INTEG);
  assign state    = cur_state;
  assign transfer = in_valid && in_ready;

  // On adder overflow the mux drives 0, so full scale is substituted
  assign x = in_sat ? '1 : in_data;

  // Saturating add of the accepted input, then leak floored at zero
  assign sum    = {1'b0, vmem} + (ACC_W + 1)'(x);
  assign base   = transfer ? (sum[ACC_W] ? '1 : sum[ACC_W-1:0]) : vmem;
  assign leaked = ({1'b0, base} >= LEAK_X) ? (base - LEAK_X[ACC_W-1:0]) : '0;

  // Next-state and datapath updates for each phase
  always_comb begin
    next_state      = cur_state;
    vmem_next       = vmem;
    refrac_cnt_next = refrac_cnt;
    spike_cnt_next  = spike_cnt;
    case (cur_state)
      ST_INTEG: begin
        vmem_next = leaked;
        if (leaked >= THRESH_V) next_state = ST_FIRE;
      end
      ST_FIRE: begin
`ifdef NEURON_SOFT_RESET_EN
        vmem_next = vmem - THRESH_V;
`else
        vmem_next = '0;
`endif
        if (spike_cnt != '1) spike_cnt_next = spike_cnt + 16'd1;
        if (REFRAC == 0) begin
          next_state = ST_INTEG;
        end else begin
          refrac_cnt_next = REFRAC_V;
          next_state      = ST_REFRAC;
        end
      end
      ST_REFRAC: begin
        refrac_cnt_next = refrac_cnt - 1'b1;
        if (refrac_cnt <= CNT_W'(1)) next_state = ST_INTEG;
      end
      default: next_state = ST_INTEG;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= ST_INTEG;
    else     cur_state <= next_state;
  end

  // Datapath registers; spike is registered so it tracks the FIRE state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vmem       <= '0;
      refrac_cnt <= '0;
      spike_cnt  <= '0;
      spike      <= 1'b0;
    end else begin
      vmem       <= vmem_next;
      refrac_cnt <= refrac_cnt_next;
      spike_cnt  <= spike_cnt_next;
      spike      <= (next_state == ST_FIRE);
    end
  end

endmodule
